// File: rtl/pll_lock_rst_seq.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for lock with timeout/retry, qualifies stability, then releases sys_rst.
// Latency: lock rise in WAIT_LOCK to sys_rst fall = 2 sync + 1 + STABLE_CYCLES edges; no backpressure (free-running control).
// Optional macro PLL_LOCK_GLITCH_FILTER_EN: in RUN, lock loss needs LOSS_FILTER consecutive low cycles.
module pll_lock_rst_seq #(
  parameter int RST_CYCLES    = 20,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16,
  parameter int LOSS_FILTER   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       lock_ok,
  output logic       fail,
  output logic       lock_lost,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  localparam int RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTRY_W-1:0] RTRY_MAX = RTRY_W'(MAX_RETRY);

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || MAX_RETRY < 0 ||
      LOSS_FILTER < 1 || CNT_W < 1) begin : g_bad_param
    $error("pll_lock_rst_seq: illegal parameter value");
  end

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [RTRY_W-1:0]  retry, retry_nx;
  logic               loss_ev;
  logic               lock_m, lock_s;

  // pll_lock comes from the PLL's own domain; two flops before any decision
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    retry_nx = retry;
    loss_ev  = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // a lock seen on the timeout cycle still counts as a lock
        if (lock_s) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else if (cnt == TMO_LAST) begin
          cnt_nx = '0;
          if (retry == RTRY_MAX) begin
            state_nx = FAIL;
          end else begin
            retry_nx = retry + 1'b1;
            state_nx = PLL_RST;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == STB_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
          retry_nx = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        // cnt doubles as the run-of-low-lock filter counter while in RUN
        if (lock_s) begin
          cnt_nx = '0;
        end else if (cnt == CNT_W'(LOSS_FILTER - 1)) begin
          loss_ev = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
`else
        loss_ev = !lock_s;
`endif
        if (loss_ev) begin
          state_nx = PLL_RST;
          cnt_nx   = '0;
        end
      end
      FAIL: begin
        state_nx = FAIL;
      end
      default: begin
        state_nx = PLL_RST;
        cnt_nx   = '0;
      end
    endcase
  end

  // outputs decode the next state so they move on the same edge as the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLL_RST;
      cnt       <= '0;
      retry     <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      lock_ok   <= 1'b0;
      fail      <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      retry     <= retry_nx;
      if (loss_ev && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
      pll_rst   <= (state_nx == PLL_RST) || (state_nx == FAIL);
      sys_rst   <= (state_nx != RUN);
      lock_ok   <= (state_nx == RUN);
      fail      <= (state_nx == FAIL);
      lock_lost <= loss_ev;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq with short timing parameters.
module tb_pll_lock_rst_seq;

  logic       clk_tb;
  logic       rst;
  logic       pll_lock;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_ok;
  logic       fail;
  logic       lock_lost;
  logic [7:0] loss_cnt;
  logic [2:0] state_dbg;

  int n_chk = 0;
  int n_fail = 0;

  pll_lock_rst_seq #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(8),
    .MAX_RETRY(2), .CNT_W(16), .LOSS_FILTER(4)
  ) dut (
    .clk(clk_tb), .rst(rst), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .lock_ok(lock_ok), .fail(fail),
    .lock_lost(lock_lost), .loss_cnt(loss_cnt), .state_dbg(state_dbg)
  );

  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_tb);
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
    int n = 0;
    while (state_dbg !== s && n < bound) begin
      @(negedge clk_tb);
      n++;
    end
    chk(tag, 32'(state_dbg), 32'(s));
  endtask

  // call right after raising pll_lock in WAIT_LOCK
  task automatic lat_to_run(input string tag);
    int n = 0;
    do begin
      @(negedge clk_tb);
      n++;
    end while (sys_rst && n < 200);
    chk(tag, 32'(n), 32'd11);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_dbg), 32'd0);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    chk({tag, "_lock_ok"}, 32'(lock_ok), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_lost"}, 32'(lock_lost), 32'd0);
    chk({tag, "_loss_cnt"}, 32'(loss_cnt), 32'd0);
  endtask

  initial begin
    int n, hi, pulses, tmo, fail_idx, sys_max, rst_max, exp_loss;
    logic prev;

    rst = 1'b1;
    pll_lock = 1'b0;
    cyc(3);
    chk_reset_vals("por");

    // power-up: count pll_rst width, then lock 30 cycles after it falls
    rst = 1'b0;
    n = 0;
    while (pll_rst && n < 50) begin
      n++;
      @(negedge clk_tb);
    end
    chk("pu_pll_rst_width", 32'(n), 32'd4);
    chk("pu_wait_state", 32'(state_dbg), 32'd1);
    cyc(30);
    pll_lock = 1'b1;
    lat_to_run("pu_latency");
    chk("pu_lock_ok", 32'(lock_ok), 32'd1);
    chk("pu_state_run", 32'(state_dbg), 32'd3);
    chk("pu_pll_rst_low", 32'(pll_rst), 32'd0);
    chk("pu_loss_cnt", 32'(loss_cnt), 32'd0);

    // lock low for 10 cycles in RUN
    pll_lock = 1'b0;
    pulses = 0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_tb);
      if (lock_lost) pulses++;
      if (pll_rst) hi++;
    end
    chk("loss_pulses", 32'(pulses), 32'd1);
    chk("loss_cnt_1", 32'(loss_cnt), 32'd1);
    chk("loss_pll_rst_width", 32'(hi), 32'd4);
    chk("loss_sys_rst", 32'(sys_rst), 32'd1);
    chk("loss_lock_ok", 32'(lock_ok), 32'd0);
    chk("loss_state_wait", 32'(state_dbg), 32'd1);
    pll_lock = 1'b1;
    lat_to_run("loss_relock_latency");
    chk("loss_relock_ok", 32'(lock_ok), 32'd1);

    // two-cycle glitch in RUN
    pll_lock = 1'b0;
    pulses = 0;
    sys_max = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) pll_lock = 1'b1;
      @(negedge clk_tb);
      if (lock_lost) pulses++;
      if (sys_rst) sys_max = 1;
    end
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    exp_loss = 1;
    chk("glitch_pulses", 32'(pulses), 32'd0);
    chk("glitch_sys_rst", 32'(sys_max), 32'd0);
`else
    exp_loss = 2;
    chk("glitch_pulses", 32'(pulses), 32'd1);
    chk("glitch_sys_rst", 32'(sys_max), 32'd1);
`endif
    chk("glitch_loss_cnt", 32'(loss_cnt), 32'(exp_loss));
    n = 0;
    while (!lock_ok && n < 100) begin
      @(negedge clk_tb);
      n++;
    end
    chk("glitch_run", 32'(lock_ok), 32'd1);

    // reset from RUN, then drop lock part-way through STABLE
    rst = 1'b1;
    pll_lock = 1'b0;
    cyc(1);
    chk_reset_vals("rst_run");
    rst = 1'b0;
    wait_state(3'd1, 20, "sd_reach_wait");
    pll_lock = 1'b1;
    wait_state(3'd2, 10, "sd_reach_stable");
    cyc(3);
    pll_lock = 1'b0;
    rst_max = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_tb);
      if (pll_rst) rst_max = 1;
    end
    chk("sd_back_to_wait", 32'(state_dbg), 32'd1);
    chk("sd_no_pll_rst", 32'(rst_max), 32'd0);
    chk("sd_sys_rst", 32'(sys_rst), 32'd1);
    cyc(5);
    pll_lock = 1'b1;
    lat_to_run("sd_relock_latency");

    // lock never asserts: three pulses then FAIL
    rst = 1'b1;
    pll_lock = 1'b0;
    cyc(1);
    rst = 1'b0;
    hi = 0;
    pulses = 0;
    prev = 1'b0;
    fail_idx = -1;
    for (int idx = 0; idx < 400 && fail_idx < 0; idx++) begin
      if (fail) begin
        fail_idx = idx;
      end else begin
        if (pll_rst) begin
          hi++;
          if (!prev) pulses++;
        end
        prev = pll_rst;
        @(negedge clk_tb);
      end
    end
    chk("to_fail_index", 32'(fail_idx), 32'd312);
    chk("to_pulse_count", 32'(pulses), 32'd3);
    chk("to_high_cycles", 32'(hi), 32'd12);
    chk("to_state_fail", 32'(state_dbg), 32'd4);
    chk("to_pll_rst", 32'(pll_rst), 32'd1);
    chk("to_sys_rst", 32'(sys_rst), 32'd1);
    pll_lock = 1'b1;
    cyc(20);
    chk("to_terminal_state", 32'(state_dbg), 32'd4);
    chk("to_terminal_fail", 32'(fail), 32'd1);

    // reset while in STABLE, then saturate loss_cnt
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    wait_state(3'd2, 30, "sat_reach_stable");
    rst = 1'b1;
    cyc(1);
    chk_reset_vals("rst_stable");
    rst = 1'b0;
    n = 0;
    while (!lock_ok && n < 100) begin
      @(negedge clk_tb);
      n++;
    end
    chk("sat_first_run", 32'(lock_ok), 32'd1);
    tmo = 0;
    for (int i = 0; i < 256; i++) begin
      pll_lock = 1'b0;
      n = 0;
      while (!lock_lost && n < 40) begin
        @(negedge clk_tb);
        n++;
      end
      if (!lock_lost) tmo++;
      pll_lock = 1'b1;
      n = 0;
      while (!lock_ok && n < 100) begin
        @(negedge clk_tb);
        n++;
      end
      if (!lock_ok) tmo++;
      if (i == 0) chk("sat_cnt_1", 32'(loss_cnt), 32'd1);
      if (i == 253) chk("sat_cnt_254", 32'(loss_cnt), 32'd254);
    end
    chk("sat_no_timeouts", 32'(tmo), 32'd0);
    chk("sat_cnt_255", 32'(loss_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_rst_seq.md
Name: pll_lock_rst_seq

Overview:
- Reset/lock sequencer that drives pll_rst into pll_sd and consumes its pll_lock.
- Runs on the free-running 50 MHz reference clock, the same clock that feeds clkin1.
- Pulses the PLL reset, waits for lock with a timeout and retry limit, then qualifies lock as stable before releasing sys_rst to downstream SD logic.
- Monitors lock loss in run and re-sequences the PLL automatically.

Parameters:
- RST_CYCLES, 20: clk cycles pll_rst is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 50000: cycles to wait for lock before retrying (>=1).
- STABLE_CYCLES, 64: consecutive synchronized lock-high cycles required before run (>=1).
- MAX_RETRY, 3: timeout retries allowed before entering FAIL (>=0).
- CNT_W, 16: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) - 1.
- LOSS_FILTER, 4: consecutive low cycles that define lock loss (used only with the optional feature).

Ports:
- clk, in, 1: reference clock, same source as clkin1.
- rst, in, 1: synchronous, active-high reset.
- pll_lock, in, 1: lock from pll_sd; asynchronous to clk.
- pll_rst, out, 1: reset to pll_sd, active-high.
- sys_rst, out, 1: active-high reset for downstream logic; high until run.
- lock_ok, out, 1: high only in RUN.
- fail, out, 1: high in FAIL (retry budget exhausted).
- lock_lost, out, 1: one-cycle pulse on loss of lock in RUN.
- loss_cnt, out, 8: lock-loss event count, saturates at 255.
- state_dbg, out, 3: current state encoding.

Behaviour:
- Reset is synchronous and active-high; the design has one clock, clk. pll_lock passes through a 2-flop synchronizer (reset to 0) to form lock_s. All decisions use lock_s.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- While rst=1, the next edge sets:
  - state=PLL_RST, cnt=0, retry=0, loss_cnt=0;
  - pll_rst=1, sys_rst=1, lock_ok=0, fail=0, lock_lost=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- PLL_RST:
  - pll_rst=1 for exactly RST_CYCLES cycles; cnt counts 0..RST_CYCLES-1.
  - At cnt==RST_CYCLES-1: go to WAIT_LOCK, cnt=0.
- WAIT_LOCK:
  - pll_rst=0.
  - If lock_s=1: go to STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT-1:
    - if retry==MAX_RETRY, go to FAIL;
    - otherwise retry++, go to PLL_RST, cnt=0.
  - Otherwise cnt++.
- STABLE:
  - If lock_s=0: go to WAIT_LOCK, cnt=0. The timeout restarts and retry is not incremented.
  - Else at cnt==STABLE_CYCLES-1: go to RUN, retry=0.
- RUN:
  - sys_rst=0, lock_ok=1.
  - On a loss event: lock_lost=1 for one cycle (coincident with the transition), loss_cnt++ (saturating at 255), go to PLL_RST, cnt=0.
  - On that same edge: sys_rst=1 and lock_ok=0.
- FAIL:
  - pll_rst=1, sys_rst=1, fail=1.
  - Terminal; only rst exits.
- Latency: from pll_lock rising (held high) in WAIT_LOCK to sys_rst falling is 2 sync + 1 + STABLE_CYCLES clk edges.
- Precedence: rst overrides everything. In WAIT_LOCK, lock_s=1 wins over a timeout in the same cycle.
- The retry counter is ceil(log2(MAX_RETRY+1)) bits wide. MAX_RETRY=0 means the first timeout goes to FAIL.
- Reset mid-sequence (any state) returns to PLL_RST with all counters cleared. The next cycle re-asserts pll_rst with a full RST_CYCLES pulse.

Optional Feature:
- Macro: PLL_LOCK_GLITCH_FILTER_EN.
- Defined: in RUN, a loss event requires lock_s=0 for LOSS_FILTER consecutive cycles.
  - A filter counter clears on any lock_s=1.
  - Shorter glitches are ignored: no pulse, no count, and sys_rst stays 0.
- Undefined: a single lock_s=0 cycle in RUN is a loss event. The LOSS_FILTER parameter is unused.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRY=2, LOSS_FILTER=4):
- Power-up, lock rises 30 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst falls 11 edges after lock rises; lock_ok=1; loss_cnt=0.
- Lock never asserts -> three pll_rst pulses of 4 cycles, each separated by 100 low cycles; fail=1 at the third timeout; pll_rst and sys_rst stay 1.
- Lock drops after 5 stable cycles -> returns to WAIT_LOCK with no pll_rst pulse; relocks; sys_rst falls after 8 fresh stable cycles.
- In RUN, lock low for 10 cycles -> lock_lost single pulse; loss_cnt=1; sys_rst=1; new 4-cycle pll_rst; recovery to RUN when lock returns.
- In RUN, 2-cycle lock glitch -> with the macro: no effect. Without it: lock_lost pulse, loss_cnt=1.
- rst asserted in STABLE, then 256 forced loss events -> all outputs return to reset values; loss_cnt saturates at 255.
